// File: rtl/lcd_text_sequencer_if.sv
// Parser byte stream in (valid/ready) and one-byte transaction bus out to the HD44780 4-bit driver.
// master = sequencer side, slave = parser/driver side.
interface lcd_text_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       lcd_ready;
    logic       lcd_write;
    logic [7:0] lcd_byte;
    logic       lcd_data1cmd0;

    modport master (
        input  in_data, in_valid, lcd_ready,
        output in_ready, lcd_write, lcd_byte, lcd_data1cmd0
    );

    modport slave (
        output in_data, in_valid, lcd_ready,
        input  in_ready, lcd_write, lcd_byte, lcd_data1cmd0
    );
endinterface

// File: rtl/lcd_text_sequencer.sv
// Buffers ASCII bytes, runs LCD init, tracks cursor/line wrap, issues one byte per driver transaction.
// Latency: IDLE->FETCH->ISSUE gives a strobe 3 cycles after a byte lands; in_ready = !full, one transaction in flight.
module lcd_text_sequencer #(
    parameter int COLS       = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CLEAR_WAIT = 82000
) (
    input  logic                        clk,
    input  logic                        reset,
    lcd_text_sequencer_if.master        bus,
    output logic                        cursor_row,
    output logic [$clog2(COLS+1)-1:0]   cursor_col
);
    localparam int CW = $clog2(COLS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = (CLEAR_WAIT > 0) ? $clog2(CLEAR_WAIT + 1) : 1;

    typedef enum logic [2:0] {
        S_CFG, S_ISSUE, S_ACK_LOW, S_ACK_HIGH, S_CLR_WAIT, S_IDLE, S_FETCH
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cfg_idx_q, cfg_idx_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [7:0]     pend_byte_q, pend_byte_d;
    logic           pend_dc_q, pend_dc_d;
    logic           pend_pop_q, pend_pop_d;
    logic           pend_row_q, pend_row_d;
    logic [CW-1:0]  pend_col_q, pend_col_d;
    logic           lcd_write_q, lcd_write_d;
    logic [7:0]     lcd_byte_q, lcd_byte_d;
    logic           lcd_dc_q, lcd_dc_d;
    logic           row_q, row_d;
    logic [CW-1:0]  col_q, col_d;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]  count_q, count_d;
    logic           push, pop, full, empty, cfg_done;
    logic [7:0]     head;

    function automatic logic [7:0] cfg_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_cmd = 8'h28;
            3'd1:    cfg_cmd = 8'h0C;
            3'd2:    cfg_cmd = 8'h01;
            default: cfg_cmd = 8'h06;
        endcase
    endfunction

    assign full     = (count_q == NW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = bus.in_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign cfg_done = (cfg_idx_q == 3'd4);

    assign bus.in_ready      = !full;
    assign bus.lcd_write     = lcd_write_q;
    assign bus.lcd_byte      = lcd_byte_q;
    assign bus.lcd_data1cmd0 = lcd_dc_q;
    assign cursor_row        = row_q;
    assign cursor_col        = col_q;

    always_comb begin
        state_d     = state_q;
        cfg_idx_d   = cfg_idx_q;
        wait_d      = wait_q;
        pend_byte_d = pend_byte_q;
        pend_dc_d   = pend_dc_q;
        pend_pop_d  = pend_pop_q;
        pend_row_d  = pend_row_q;
        pend_col_d  = pend_col_q;
        lcd_write_d = 1'b0;
        lcd_byte_d  = lcd_byte_q;
        lcd_dc_d    = lcd_dc_q;
        row_d       = row_q;
        col_d       = col_q;
        pop         = 1'b0;

        case (state_q)
            S_CFG: begin
                pend_byte_d = cfg_cmd(cfg_idx_q);
                pend_dc_d   = 1'b0;
                pend_pop_d  = 1'b0;
                pend_row_d  = row_q;
                pend_col_d  = col_q;
                cfg_idx_d   = cfg_idx_q + 3'd1;
                state_d     = S_ISSUE;
            end
            // Cursor moves and the FIFO pops on the same edge that raises the strobe.
            S_ISSUE: begin
                if (bus.lcd_ready) begin
                    lcd_write_d = 1'b1;
                    lcd_byte_d  = pend_byte_q;
                    lcd_dc_d    = pend_dc_q;
                    pop         = pend_pop_q;
                    row_d       = pend_row_q;
                    col_d       = pend_col_q;
                    state_d     = S_ACK_LOW;
                end
            end
            S_ACK_LOW: begin
                if (!bus.lcd_ready) state_d = S_ACK_HIGH;
            end
            S_ACK_HIGH: begin
                if (bus.lcd_ready) begin
                    if (!pend_dc_q && pend_byte_q == 8'h01 && CLEAR_WAIT > 0) begin
                        wait_d  = WW'(CLEAR_WAIT);
                        state_d = S_CLR_WAIT;
                    end else begin
                        state_d = cfg_done ? S_IDLE : S_CFG;
                    end
                end
            end
            S_CLR_WAIT: begin
                if (wait_q == WW'(1)) state_d = cfg_done ? S_IDLE : S_CFG;
                else                  wait_d  = wait_q - WW'(1);
            end
            S_IDLE: begin
                if (!empty) state_d = S_FETCH;
            end
            S_FETCH: begin
                pend_pop_d = 1'b1;
                pend_dc_d  = 1'b0;
                pend_row_d = row_q;
                pend_col_d = '0;
                state_d    = S_ISSUE;
                if (head >= 8'h20 && head <= 8'h7E) begin
                    if (col_q != CW'(COLS)) begin
                        pend_byte_d = head;
                        pend_dc_d   = 1'b1;
                        pend_col_d  = col_q + 1'b1;
                    end else begin
                        // Line full: move to the other line first, the char stays queued.
                        pend_byte_d = row_q ? 8'h80 : 8'hC0;
                        pend_row_d  = !row_q;
                        pend_pop_d  = 1'b0;
                    end
                end else if (head == 8'h0A) begin
                    pend_byte_d = row_q ? 8'h80 : 8'hC0;
                    pend_row_d  = !row_q;
                end else if (head == 8'h0D) begin
                    pend_byte_d = row_q ? 8'hC0 : 8'h80;
                end else if (head == 8'h0C) begin
                    pend_byte_d = 8'h01;
                    pend_row_d  = 1'b0;
                end else begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CFG;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + NW'(push) - NW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CFG;
            cfg_idx_q   <= '0;
            wait_q      <= '0;
            pend_byte_q <= '0;
            pend_dc_q   <= 1'b0;
            pend_pop_q  <= 1'b0;
            pend_row_q  <= 1'b0;
            pend_col_q  <= '0;
            lcd_write_q <= 1'b0;
            lcd_byte_q  <= '0;
            lcd_dc_q    <= 1'b0;
            row_q       <= 1'b0;
            col_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cfg_idx_q   <= cfg_idx_d;
            wait_q      <= wait_d;
            pend_byte_q <= pend_byte_d;
            pend_dc_q   <= pend_dc_d;
            pend_pop_q  <= pend_pop_d;
            pend_row_q  <= pend_row_d;
            pend_col_q  <= pend_col_d;
            lcd_write_q <= lcd_write_d;
            lcd_byte_q  <= lcd_byte_d;
            lcd_dc_q    <= lcd_dc_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end
endmodule
